// File: rtl/parking_entry_terminal.sv
// Parking entry terminal: debounces the vehicle loop, collects a 4-bit keypad
// password, presents it to parking_system and drives the barrier gate.
// Optional build macro ENTRY_STATS_EN adds saturating admitted/rejected counters.
module parking_entry_terminal #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int RESP_TIMEOUT     = 64,
  parameter int MAX_TRIES        = 3,
  parameter int GATE_OPEN_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_arrive_raw,
  input  logic       key_valid,
  input  logic       key_bit,
  input  logic       key_clear,
  input  logic       green_led,
  input  logic       red_led,
  output logic       sensor_entrance,
  output logic [3:0] password,
  output logic       gate_open,
  output logic       lockout,
  output logic [1:0] tries_left,
  output logic [2:0] state_o
`ifdef ENTRY_STATS_EN
  ,
  output logic [7:0] admitted_count,
  output logic [7:0] rejected_count
`endif
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RESP_W = $clog2(RESP_TIMEOUT) + 1;
  localparam int GATE_W = $clog2(GATE_OPEN_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RESP_W-1:0] RESP_LAST  = RESP_W'(RESP_TIMEOUT - 1);
  localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [1:0]        TRIES_INIT = 2'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    PRESENT = 3'd2,
    GATE    = 3'd3,
    FAIL    = 3'd4,
    LOCKOUT = 3'd5
  } state_t;

  state_t            state;
  logic              sync1, sync2, car_db;
  logic [DB_W-1:0]   db_cnt;
  logic              db_hit, car_now;
  logic [3:0]        shift_reg, shift_next;
  logic [1:0]        bit_cnt;
  logic [RESP_W-1:0] resp_tmr;
  logic [GATE_W-1:0] gate_tmr;

  // red_led is status for the driver display only; the sequencing ignores it.
  logic unused_red;
  assign unused_red = red_led;

  // The FSM reacts to the debounced level in the same cycle car_db toggles,
  // so sensor_entrance follows the debounced car without an extra stage.
  always_comb begin
    db_hit     = (sync2 != car_db) && (db_cnt == DB_LAST);
    car_now    = db_hit ? ~car_db : car_db;
    shift_next = {shift_reg[2:0], key_bit};
  end

  // Two-flop synchronizer plus stability counter for the loop detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      car_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= car_arrive_raw;
      sync2 <= sync1;
      if (sync2 != car_db) begin
        if (db_hit) begin
          car_db <= ~car_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Entry sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sensor_entrance <= 1'b0;
      password        <= 4'd0;
      gate_open       <= 1'b0;
      lockout         <= 1'b0;
      tries_left      <= TRIES_INIT;
      shift_reg       <= 4'd0;
      bit_cnt         <= 2'd0;
      resp_tmr        <= '0;
      gate_tmr        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (car_now) begin
            state           <= COLLECT;
            sensor_entrance <= 1'b1;
            bit_cnt         <= 2'd0;
            shift_reg       <= 4'd0;
            tries_left      <= TRIES_INIT;
          end
        end
        COLLECT: begin
          if (!car_now) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
          end else if (key_clear) begin
            bit_cnt   <= 2'd0;
            shift_reg <= 4'd0;
          end else if (key_valid) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 2'd1;
            if (bit_cnt == 2'd3) begin
              state    <= PRESENT;
              password <= shift_next;
              resp_tmr <= '0;
            end
          end
        end
        PRESENT: begin
          if (!car_now) begin
            state           <= IDLE;
            sensor_entrance <= 1'b0;
            password        <= 4'd0;
          end else if (green_led) begin
            state           <= GATE;
            gate_open       <= 1'b1;
            sensor_entrance <= 1'b0;
            gate_tmr        <= '0;
          end else if (resp_tmr == RESP_LAST) begin
            state           <= FAIL;
            sensor_entrance <= 1'b0;
            password        <= 4'd0;
            tries_left      <= (tries_left == 2'd0) ? 2'd0 : tries_left - 2'd1;
          end else begin
            resp_tmr <= resp_tmr + 1'b1;
          end
        end
        GATE: begin
          // Never close on a car still standing under the barrier.
          if ((gate_tmr >= GATE_LAST) && !car_now) begin
            state     <= IDLE;
            gate_open <= 1'b0;
            password  <= 4'd0;
          end else if (gate_tmr < GATE_LAST) begin
            gate_tmr <= gate_tmr + 1'b1;
          end
        end
        FAIL: begin
          if (tries_left == 2'd0) begin
            state   <= LOCKOUT;
            lockout <= 1'b1;
          end else begin
            state           <= COLLECT;
            sensor_entrance <= 1'b1;
            bit_cnt         <= 2'd0;
            shift_reg       <= 4'd0;
          end
        end
        LOCKOUT: begin
          if (!car_now) begin
            state      <= IDLE;
            lockout    <= 1'b0;
            tries_left <= TRIES_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_o = state;

`ifdef ENTRY_STATS_EN
  // Saturating counts of admitted cars and rejected attempts.
  always_ff @(posedge clk) begin
    if (reset) begin
      admitted_count <= 8'd0;
      rejected_count <= 8'd0;
    end else begin
      if ((state == PRESENT) && car_now && green_led && (admitted_count != 8'hFF))
        admitted_count <= admitted_count + 8'd1;
      if ((state == FAIL) && (rejected_count != 8'hFF))
        rejected_count <= rejected_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_entry_terminal.sv
// Self-checking bench for parking_entry_terminal: directed scenarios with
// literal expectations, then randomized traffic checked against a
// behavioural model every cycle.
module tb_parking_entry_terminal;

  localparam int DEB   = 4;
  localparam int RESP  = 64;
  localparam int TRIES = 3;
  localparam int GATEC = 32;

  logic       clk = 1'b0;
  logic       reset, car_arrive_raw, key_valid, key_bit, key_clear, green_led, red_led;
  logic       sensor_entrance, gate_open, lockout;
  logic [3:0] password;
  logic [1:0] tries_left;
  logic [2:0] state_o;
`ifdef ENTRY_STATS_EN
  logic [7:0] admitted_count, rejected_count;
`endif

  parking_entry_terminal dut (
    .clk             (clk),
    .reset           (reset),
    .car_arrive_raw  (car_arrive_raw),
    .key_valid       (key_valid),
    .key_bit         (key_bit),
    .key_clear       (key_clear),
    .green_led       (green_led),
    .red_led         (red_led),
    .sensor_entrance (sensor_entrance),
    .password        (password),
    .gate_open       (gate_open),
    .lockout         (lockout),
    .tries_left      (tries_left),
    .state_o         (state_o)
`ifdef ENTRY_STATS_EN
    ,
    .admitted_count  (admitted_count),
    .rejected_count  (rejected_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   started = 1'b0;
  bit   hist[$];
  bit   seen;
  int   streak;
  bit   m_car;
  int   m_state, m_wait, m_tries, m_adm, m_rej;
  bit   m_sens, m_gate, m_lock;
  logic [3:0] m_pw;
  bit   keys[$];

  always @(posedge clk) begin
    if (reset) begin
      hist.delete(); keys.delete();
      streak = 0; m_car = 0; m_state = 0; m_wait = 0; m_tries = TRIES;
      m_sens = 0; m_gate = 0; m_lock = 0; m_pw = 4'd0; m_adm = 0; m_rej = 0;
    end else begin
      // car level seen two samples late; it flips after DEB consecutive disagreeing samples
      hist.push_back(car_arrive_raw);
      seen = (hist.size() >= 3) ? hist[hist.size()-3] : 1'b0;
      if (hist.size() > 8) void'(hist.pop_front());
      if (seen != m_car) streak++; else streak = 0;
      if (streak == DEB) begin m_car = !m_car; streak = 0; end

      case (m_state)
        0: if (m_car) begin m_state = 1; m_sens = 1; keys.delete(); m_tries = TRIES; end
        1: begin
          if (!m_car) begin m_state = 0; m_sens = 0; end
          else if (key_clear) keys.delete();
          else if (key_valid) begin
            keys.push_back(key_bit);
            if (keys.size() == 4) begin
              m_pw = {keys[0], keys[1], keys[2], keys[3]};
              m_state = 2; m_wait = 0;
            end
          end
        end
        2: begin
          if (!m_car) begin m_state = 0; m_sens = 0; m_pw = 4'd0; end
          else if (green_led) begin
            m_state = 3; m_gate = 1; m_sens = 0; m_wait = 0;
            if (m_adm < 255) m_adm++;
          end else if (m_wait == RESP - 1) begin
            m_state = 4; m_sens = 0; m_pw = 4'd0;
            if (m_tries > 0) m_tries--;
          end else m_wait++;
        end
        3: begin
          if (m_wait >= GATEC - 1 && !m_car) begin m_state = 0; m_gate = 0; m_pw = 4'd0; end
          else m_wait++;
        end
        4: begin
          if (m_rej < 255) m_rej++;
          if (m_tries == 0) begin m_state = 5; m_lock = 1; end
          else begin m_state = 1; m_sens = 1; keys.delete(); end
        end
        default: if (!m_car) begin m_state = 0; m_lock = 0; m_tries = TRIES; end
      endcase
    end
    started = 1'b1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("state_o", state_o, m_state);
      check("sensor_entrance", sensor_entrance, m_sens);
      check("password", password, m_pw);
      check("gate_open", gate_open, m_gate);
      check("lockout", lockout, m_lock);
      check("tries_left", tries_left, m_tries);
`ifdef ENTRY_STATS_EN
      check("admitted_count", admitted_count, m_adm);
      check("rejected_count", rejected_count, m_rej);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit b, input bit clr);
    key_valid = 1'b1; key_bit = b; key_clear = clr;
    @(negedge clk);
    key_valid = 1'b0; key_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1; car_arrive_raw = 0; key_valid = 0; key_bit = 0;
    key_clear = 0; green_led = 0; red_led = 0;
    cyc(3);
    check("rst_state", state_o, 0);
    check("rst_tries", tries_left, 3);
    check("rst_sensor", sensor_entrance, 0);
    check("rst_gate", gate_open, 0);
    reset = 0;
    cyc(2);

    // 3-cycle pulse is filtered
    car_arrive_raw = 1; cyc(3); car_arrive_raw = 0; cyc(10);
    check("pulse_idle", state_o, 0);

    // bounce 1-0-1 then hold: rises 6 cycles after final edge
    car_arrive_raw = 1; cyc(1); car_arrive_raw = 0; cyc(1); car_arrive_raw = 1;
    cyc(5);
    check("db_lat5", sensor_entrance, 0);
    cyc(1);
    check("db_lat6", sensor_entrance, 1);
    check("db_state", state_o, 1);

    // correct entry 1011, green after 10 cycles
    press(1, 0); press(0, 0); press(1, 0); press(1, 0);
    check("ok_state", state_o, 2);
    check("ok_pw", password, 4'b1011);
    cyc(8);
    green_led = 1; cyc(1); green_led = 0;
    check("gate_state", state_o, 3);
    n = 0;
    while (gate_open && n < 200) begin
      n++;
      @(negedge clk);
      if (n == 3) car_arrive_raw = 0;
    end
    check("gate_len", n, 32);
    check("gate_idle", state_o, 0);

    // three wrong entries -> lockout
    car_arrive_raw = 1; cyc(8);
    check("arrive2", state_o, 1);
    for (int i = 0; i < 3; i++) begin
      press(0, 0); press(0, 0); press(0, 0); press(0, 0);
      n = 2;
      while (state_o == 2 && n < 200) begin
        @(negedge clk);
        if (state_o == 2) n++;
      end
      check("present_len", n, 64);
      check("fail_state", state_o, 4);
      check("fail_tries", tries_left, 2 - i);
      cyc(1);
      check("after_fail", state_o, (i == 2) ? 5 : 1);
    end
    check("lockout", lockout, 1);
    press(1, 0); press(1, 0);
    check("lock_keys", state_o, 5);
    car_arrive_raw = 0; cyc(7);
    check("unlock_state", state_o, 0);
    check("unlock_tries", tries_left, 3);
    check("unlock_flag", lockout, 0);

    // clear coincident with 3rd key
    car_arrive_raw = 1; cyc(8);
    press(1, 0); press(0, 0); press(1, 1);
    check("clr_state", state_o, 1);
    press(1, 0); press(1, 0); press(1, 0); press(1, 0);
    check("clr_state2", state_o, 2);
    check("clr_pw", password, 4'b1111);

    // departure mid-PRESENT
    car_arrive_raw = 0;
    n = 0;
    while (state_o != 0 && n < 20) begin @(negedge clk); n++; end
    check("depart_within", (n <= DEB + 2) ? 1 : 0, 1);
    check("depart_sensor", sensor_entrance, 0);
    check("depart_pw", password, 0);
`ifdef ENTRY_STATS_EN
    check("stat_adm", admitted_count, 1);
    check("stat_rej", rejected_count, 3);
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) car_arrive_raw = !car_arrive_raw;
      key_valid = ($urandom_range(0, 3) == 0);
      key_bit   = 1'($urandom_range(0, 1));
      key_clear = ($urandom_range(0, 19) == 0);
      green_led = ($urandom_range(0, 39) == 0);
      red_led   = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 1499) == 0);
      @(negedge clk);
    end
    reset = 0; key_valid = 0; key_clear = 0; green_led = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
